// File: rtl/decode_if.sv
// decode_if: upstream instruction handshake, flush and downstream decoded bundle for decode_stage
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [31:0]     INSTR;
    logic [PC_W-1:0] PC_IN;
    logic            FLUSH;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [4:0]      RS1;
    logic [4:0]      RS2;
    logic [4:0]      RD;
    logic [3:0]      ALU_OP;
    logic            ALU_SRC;
    logic [XLEN-1:0] IMM;
    logic            REG_WR;
    logic            BR;
    logic [2:0]      BR_F3;
    logic            JAL;
    logic            JALR;
    logic            LOAD;
    logic            STORE;
    logic            ILLEGAL;
    logic [PC_W-1:0] PC_OUT;
    logic [CNT_W-1:0] DEC_CNT;

    modport master (
        output IN_VALID, INSTR, PC_IN, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, RS1, RS2, RD, ALU_OP, ALU_SRC, IMM, REG_WR, BR, BR_F3,
               JAL, JALR, LOAD, STORE, ILLEGAL, PC_OUT, DEC_CNT
    );

    modport slave (
        input  IN_VALID, INSTR, PC_IN, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, RS1, RS2, RD, ALU_OP, ALU_SRC, IMM, REG_WR, BR, BR_F3,
               JAL, JALR, LOAD, STORE, ILLEGAL, PC_OUT, DEC_CNT
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder with a one-entry registered output bundle and valid/ready handshakes
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input logic     CLK,
    input logic     RST,
    decode_if.slave bus
);
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_LT    = 4'd3;
    localparam logic [3:0] ALU_LTU   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic [XLEN-1:0] imm;
        logic            reg_wr;
        logic            br;
        logic [2:0]      br_f3;
        logic            jal;
        logic            jalr;
        logic            load;
        logic            store;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } bundle_t;

    bundle_t          d;
    bundle_t          q;
    logic             out_valid;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;

    assign opc = bus.INSTR[6:0];
    assign rd  = bus.INSTR[11:7];
    assign f3  = bus.INSTR[14:12];
    assign rs1 = bus.INSTR[19:15];
    assign rs2 = bus.INSTR[24:20];
    assign f7  = bus.INSTR[31:25];

    assign imm_i = XLEN'($signed(bus.INSTR[31:20]));
    assign imm_s = XLEN'($signed({bus.INSTR[31:25], bus.INSTR[11:7]}));
    assign imm_b = XLEN'($signed({bus.INSTR[31], bus.INSTR[7], bus.INSTR[30:25], bus.INSTR[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({bus.INSTR[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({bus.INSTR[31], bus.INSTR[19:12], bus.INSTR[20], bus.INSTR[30:21], 1'b0}));

    // bit 30 only means SUB for register-register ops; for ADDI it is an immediate bit
    assign alu_op = f3 == 3'b000 ? (bus.INSTR[30] && opc == OP_ALU ? ALU_SUB : ALU_ADD) :
                    f3 == 3'b001 ? ALU_SLL :
                    f3 == 3'b010 ? ALU_LT  :
                    f3 == 3'b011 ? ALU_LTU :
                    f3 == 3'b100 ? ALU_XOR :
                    f3 == 3'b101 ? (bus.INSTR[30] ? ALU_SRA : ALU_SRL) :
                    f3 == 3'b110 ? ALU_OR  : ALU_AND;

    assign capture       = bus.IN_VALID && bus.IN_READY;
    assign bus.IN_READY  = (!out_valid || bus.OUT_READY) && !bus.FLUSH && !RST;
    assign bus.OUT_VALID = out_valid;
    assign bus.DEC_CNT   = cnt;
    assign bus.RS1       = q.rs1;
    assign bus.RS2       = q.rs2;
    assign bus.RD        = q.rd;
    assign bus.ALU_OP    = q.alu_op;
    assign bus.ALU_SRC   = q.alu_src;
    assign bus.IMM       = q.imm;
    assign bus.REG_WR    = q.reg_wr;
    assign bus.BR        = q.br;
    assign bus.BR_F3     = q.br_f3;
    assign bus.JAL       = q.jal;
    assign bus.JALR      = q.jalr;
    assign bus.LOAD      = q.load;
    assign bus.STORE     = q.store;
    assign bus.ILLEGAL   = q.illegal;
    assign bus.PC_OUT    = q.pc;

    // decode the incoming word into the next bundle; illegal encodings keep fields but drop all effects
    always_comb begin
        d    = '0;
        d.pc = bus.PC_IN;
        case (opc)
            OP_ALU: begin
                d.rs1     = rs1;
                d.rs2     = rs2;
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_op  = alu_op;
                d.illegal = !(f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OP_IMM: begin
                d.rs1     = rs1;
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.imm     = imm_i;
                d.alu_op  = alu_op;
                d.illegal = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != F7_ALT);
            end
            OP_BR: begin
                d.rs1     = rs1;
                d.rs2     = rs2;
                d.br      = 1'b1;
                d.imm     = imm_b;
                d.illegal = f3 == 3'b010 || f3 == 3'b011;
            end
            OP_JAL: begin
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.jal     = 1'b1;
                d.imm     = imm_j;
            end
            OP_JALR: begin
                d.rs1     = rs1;
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.jalr    = 1'b1;
                d.imm     = imm_i;
                d.illegal = f3 != 3'b000;
            end
            OP_LOAD: begin
                d.rs1     = rs1;
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.load    = 1'b1;
                d.imm     = imm_i;
            end
            OP_STORE: begin
                d.rs1     = rs1;
                d.rs2     = rs2;
                d.alu_src = 1'b1;
                d.store   = 1'b1;
                d.imm     = imm_s;
            end
            OP_LUI: begin
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.alu_op  = ALU_PASSB;
                d.imm     = imm_u;
            end
            OP_AUIPC: begin
                d.rd      = rd;
                d.reg_wr  = 1'b1;
                d.alu_src = 1'b1;
                d.imm     = imm_u;
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.reg_wr = 1'b0;
            d.br     = 1'b0;
            d.jal    = 1'b0;
            d.jalr   = 1'b0;
            d.load   = 1'b0;
            d.store  = 1'b0;
            d.alu_op = ALU_ADD;
        end
        d.reg_wr = d.reg_wr && d.rd != 5'd0;
        d.br_f3  = d.br ? f3 : 3'b0;
    end

    // output register: capture on input handshake, drop on flush or drained handshake, count delivered bundles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            q         <= '0;
        end else begin
            if (out_valid && bus.OUT_READY && !bus.FLUSH) cnt <= cnt + 1'b1;
            out_valid <= !bus.FLUSH && (capture || (out_valid && !bus.OUT_READY));
            if (capture) q <= d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a transaction-level reference decoder
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [31:0] imm;
        logic        reg_wr;
        logic        br;
        logic [2:0]  br_f3;
        logic        jal;
        logic        jalr;
        logic        load;
        logic        store;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t cur;
    bit   valid;
    int   cnt;
    int   saved;

    decode_if #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t observed();
        return exp_t'({bus.RS1, bus.RS2, bus.RD, bus.ALU_OP, bus.ALU_SRC, bus.IMM, bus.REG_WR, bus.BR,
                       bus.BR_F3, bus.JAL, bus.JALR, bus.LOAD, bus.STORE, bus.ILLEGAL, bus.PC_OUT});
    endfunction

    // reference decoder built from the instruction-set rules with integer arithmetic
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
        exp_t e = '0;
        int f3 = int'(i[14:12]);
        int f7 = int'(i[31:25]);
        int tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int s = $signed(i);
        int ii = s >>> 20;
        e.pc = pc;
        case (i[6:0])
            7'h33: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.reg_wr = 1;
                e.alu_op = 4'(tab[f3] + ((i[30] && (f3 == 0 || f3 == 5)) ? 1 : 0));
                e.illegal = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            7'h13: begin
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.imm = ii;
                e.alu_op = 4'(tab[f3] + ((f3 == 5 && i[30]) ? 1 : 0));
                e.illegal = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            7'h63: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.br = 1; e.br_f3 = 3'(f3);
                e.imm = (i[31] ? -4096 : 0) + (int'(i[7]) << 11) + (int'(i[30:25]) << 5) + (int'(i[11:8]) << 1);
                e.illegal = f3 == 2 || f3 == 3;
            end
            7'h6f: begin
                e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.jal = 1;
                e.imm = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12) + (int'(i[20]) << 11) + (int'(i[30:21]) << 1);
            end
            7'h67: begin
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.jalr = 1; e.imm = ii;
                e.illegal = f3 != 0;
            end
            7'h03: begin
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.load = 1; e.imm = ii;
            end
            7'h23: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.alu_src = 1; e.store = 1;
                e.imm = (ii & ~32'h1f) | int'(i[11:7]);
            end
            7'h37: begin
                e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.alu_op = 10; e.imm = i & 32'hfffff000;
            end
            7'h17: begin
                e.rd = i[11:7]; e.reg_wr = 1; e.alu_src = 1; e.imm = i & 32'hfffff000;
            end
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin
            e.reg_wr = 0; e.br = 0; e.br_f3 = 0; e.jal = 0; e.jalr = 0; e.load = 0; e.store = 0; e.alu_op = 0;
        end
        if (e.rd == 0) e.reg_wr = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17};
        logic [31:0] i = $urandom;
        int k = $urandom_range(0, 9);
        i[6:0] = (k == 9) ? 7'($urandom) : ops[k];
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
        endcase
        return i;
    endfunction

    // one clock of stimulus; the model tracks the single bundle slot and the delivered count
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic ordy);
        bit rdy;
        bit hs;
        bit cap;
        bus.IN_VALID = iv;
        bus.INSTR = ins;
        bus.PC_IN = pc;
        bus.FLUSH = fl;
        bus.OUT_READY = ordy;
        #1;
        rdy = (!valid || ordy) && !fl;
        check("in_ready", bus.IN_READY, rdy);
        hs = valid && ordy && !fl;
        cap = iv && rdy;
        if (hs) cnt = (cnt + 1) % (1 << CNT_W);
        if (fl) valid = 0;
        else if (cap) begin
            valid = 1;
            cur = ref_dec(ins, pc);
        end else if (hs) valid = 0;
        @(posedge CLK);
        #1;
        check("out_valid", bus.OUT_VALID, valid);
        check("dec_cnt", bus.DEC_CNT, cnt);
        if (valid) check("bundle", observed(), cur);
        @(negedge CLK);
    endtask

    initial begin
        bus.IN_VALID = 0;
        bus.INSTR = 0;
        bus.PC_IN = 0;
        bus.FLUSH = 0;
        bus.OUT_READY = 0;
        valid = 0;
        cnt = 0;
        cur = '0;
        @(negedge CLK);
        #1;
        check("rst_valid", bus.OUT_VALID, 0);
        check("rst_cnt", bus.DEC_CNT, 0);
        check("rst_bundle", observed(), 0);
        check("rst_ready", bus.IN_READY, 0);
        RST = 0;

        step(1, 32'h002081B3, 32'h100, 0, 0);
        check("add_rs1", bus.RS1, 1);
        check("add_rs2", bus.RS2, 2);
        check("add_rd", bus.RD, 3);
        check("add_op", bus.ALU_OP, 0);
        check("add_src", bus.ALU_SRC, 0);
        check("add_wr", bus.REG_WR, 1);
        step(1, 32'hFFF00093, 32'h104, 0, 1);
        check("addi_imm", bus.IMM, 32'hFFFFFFFF);
        check("addi_src", bus.ALU_SRC, 1);
        check("addi_op", bus.ALU_OP, 0);
        step(1, 32'h123452B7, 32'h108, 0, 1);
        check("lui_imm", bus.IMM, 32'h12345000);
        check("lui_op", bus.ALU_OP, 10);
        step(1, 32'hFE208EE3, 32'h10C, 0, 1);
        check("beq_br", bus.BR, 1);
        check("beq_f3", bus.BR_F3, 0);
        check("beq_imm", bus.IMM, 32'hFFFFFFFC);
        check("beq_wr", bus.REG_WR, 0);
        step(1, 32'h00000000, 32'h110, 0, 1);
        check("zero_ill", bus.ILLEGAL, 1);
        check("zero_wr", bus.REG_WR, 0);
        saved = cnt;
        step(0, 32'h0, 32'h0, 0, 1);
        check("zero_counted", bus.DEC_CNT, (saved + 1) % 16);

        step(1, 32'h002081B3, 32'h200, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 32'h00500313, 32'h204, 0, 0);
        check("stall_rd", bus.RD, 3);
        check("stall_pc", bus.PC_OUT, 32'h200);
        saved = cnt;
        step(1, 32'h00500313, 32'h204, 1, 0);
        check("flush_valid", bus.OUT_VALID, 0);
        check("flush_cnt", bus.DEC_CNT, saved);

        step(1, 32'h123452B7, 32'h300, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0);
        #2;
        RST = 1;
        #1;
        check("arst_valid", bus.OUT_VALID, 0);
        check("arst_cnt", bus.DEC_CNT, 0);
        check("arst_bundle", observed(), 0);
        check("arst_ready", bus.IN_READY, 0);
        @(posedge CLK);
        #1;
        check("rst_hold_valid", bus.OUT_VALID, 0);
        @(negedge CLK);
        RST = 0;
        valid = 0;
        cnt = 0;

        for (int k = 0; k < 17; k++) begin
            step(1, 32'h00108093, 32'(k * 4), 0, 1);
            if (k == 15) check("cnt_15", bus.DEC_CNT, 15);
        end
        check("cnt_wrap", bus.DEC_CNT, 0);
        step(0, 32'h0, 32'h0, 0, 1);

        for (int k = 0; k < 500; k++)
            step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have the parameter XLEN, default 32, giving the immediate output width (minimum 32).
REQ-002 The module SHALL have the parameter PC_W, default 32, giving the program counter passthrough width.
REQ-003 The module SHALL have the parameter CNT_W, default 16, giving the retired-decode counter width.
REQ-004 The module SHALL have the following ports, clock and reset first:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  INSTR/PC_IN valid.
- IN_READY  out  1  stage can accept.
- INSTR  in  32  RV32I instruction word.
- PC_IN  in  PC_W  instruction address.
- FLUSH  in  1  discard held/incoming instruction.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  downstream accepts.
- RS1, RS2, RD  out  5 each  register indices.
- ALU_OP  out  4  ALU operation.
- ALU_SRC  out  1  1 = IMM is operand 2.
- IMM  out  XLEN  sign-extended immediate.
- REG_WR  out  1  register write enable.
- BR  out  1  conditional branch.
- BR_F3  out  3  branch condition (funct3).
- JAL, JALR, LOAD, STORE  out  1 each  class flags.
- ILLEGAL  out  1  unsupported encoding.
- PC_OUT  out  PC_W  registered PC_IN.
- DEC_CNT  out  CNT_W  count of bundles handed downstream.

Function
REQ-005 IN_READY SHALL equal (!OUT_VALID || OUT_READY) && !FLUSH, combinationally.
REQ-006 On a rising edge with IN_VALID && IN_READY, all decoded outputs and PC_OUT SHALL be registered from INSTR/PC_IN, and OUT_VALID SHALL be 1 on the next cycle (latency 1).
REQ-007 OUT_VALID=1 && OUT_READY=0 SHALL hold every output stable.
REQ-008 OUT_VALID && OUT_READY without a new capture SHALL clear OUT_VALID next cycle.
REQ-009 Simultaneous output handshake and input capture SHALL replace the bundle with no bubble.
REQ-010 FLUSH=1 SHALL clear OUT_VALID next cycle, block capture that cycle, and not increment DEC_CNT.
REQ-011 DEC_CNT SHALL increment by 1 on each OUT_VALID && OUT_READY && !FLUSH, wrapping from all-ones to 0.
REQ-012 Opcodes SHALL be:
- ALU 0110011
- ALU_IMM 0010011
- BRANCH 1100011
- JAL 1101111
- JALR 1100111
- LOAD 0000011
- STORE 0100011
- LUI 0110111
- AUIPC 0010111
REQ-013 ALU_OP encodings SHALL be:
- ADD 0
- SUB 1
- SLL 2
- LT 3
- LTU 4
- XOR 5
- SRL 6
- SRA 7
- OR 8
- AND 9
- PASSB 10
REQ-014 ALU and ALU_IMM decoding SHALL behave as follows:
- funct3 SHALL select the op.
- INSTR[30] SHALL select SUB (ALU only) and SRA.
- Any other funct7 value for ALU, SLLI, SRLI or SRAI SHALL set ILLEGAL.
REQ-015 IMM SHALL be formed per RV32I I/S/B/U/J format and sign-extended from bit 31 to XLEN:
- B and J immediates SHALL have bit 0 = 0.
- U immediates SHALL have bits 11:0 = 0.
- R-type instructions SHALL produce IMM=0.
REQ-016 Control decoding SHALL be:
- REG_WR=1 for ALU, ALU_IMM, LOAD, LUI, AUIPC, JAL and JALR.
- REG_WR SHALL be forced to 0 when RD=0.
- ALU_SRC=1 for all classes except ALU and BRANCH.
- LUI SHALL use PASSB.
- AUIPC, LOAD, STORE, JAL and JALR SHALL use ADD.
REQ-017 BRANCH with funct3 010 or 011, and JALR with funct3≠000, SHALL set ILLEGAL.
REQ-018 An unknown opcode SHALL set ILLEGAL.
REQ-019 When ILLEGAL=1, REG_WR, BR, JAL, JALR, LOAD and STORE SHALL be 0 and ALU_OP SHALL be ADD; the bundle SHALL still be valid and counted.
REQ-020 BR_F3 SHALL be INSTR[14:12] when BR=1, else 0.
REQ-021 Unused RS1/RS2 fields SHALL be 0.

Reset
REQ-022 RST=1 SHALL immediately, without waiting for a clock edge, drive OUT_VALID=0, DEC_CNT=0 and all decoded outputs, PC_OUT included, to 0.
REQ-023 While RST=1, IN_READY SHALL be 0.
REQ-024 Reset asserted mid-stall SHALL discard the held bundle, and that bundle SHALL not be counted.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- 0x002081B3 (add x3,x1,x2) -> RS1=1, RS2=2, RD=3, ALU_OP=0, ALU_SRC=0, REG_WR=1, one cycle after capture.
- 0xFFF00093 (addi x1,x0,-1) -> IMM=0xFFFFFFFF, ALU_SRC=1, ALU_OP=0; 0x123452B7 (lui x5) -> IMM=0x12345000, ALU_OP=10.
- 0xFE208EE3 (beq x1,x2,-4) -> BR=1, BR_F3=0, IMM=0xFFFFFFFC, REG_WR=0.
- 0x00000000 -> ILLEGAL=1, REG_WR=0, DEC_CNT increments on handshake.
- OUT_READY=0 for 3 cycles with IN_VALID=1 -> outputs stable and IN_READY=0; then FLUSH -> OUT_VALID=0 and DEC_CNT unchanged.
- RST pulse mid-stall -> OUT_VALID=0 and DEC_CNT=0 with no clock edge; DEC_CNT with CNT_W=4 wraps 15->0.
